tennis_score_keeper: RTL and testbench
======================================

Name: tennis_score_keeper

Overview:
- Sits directly downstream of the tennis game core.
- Watches the ball shift-register bus nL each ball-move tick and decides when a point ends and which player won it.
- Runs standard game scoring (0/15/30/40/deuce/advantage) and per-player game counts.
- Presents BCD-style score codes and one-cycle event pulses for the display multiplexer.

Parameters:
- GAME_LIMIT, 9: game count at which a player's games counter saturates (max 15).
- HOLD_TICKS, 6: number of move ticks the finished-game score is frozen before points clear (1..63).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- move_tick  in  1  one-cycle pulse when the ball shift register may update.
- nL  in  8  negative-true ball position; bit 7 is leftmost; all ones means no ball in play.
- pts_left  out  4  left point code: 0=0, 1=15, 2=30, 3=40, 4=Ad, 5=blank.
- pts_right  out  4  right point code, same encoding.
- games_left  out  4  left games won, binary.
- games_right  out  4  right games won, binary.
- point_pulse  out  1  one-cycle pulse on every awarded point.
- point_to_right  out  1  winner of the last awarded point: 1 = right; held until the next point.
- game_pulse  out  1  one-cycle pulse when a game is won.
- holding  out  1  high while the finished-game score is frozen.

Behaviour:
- Reset values: all point codes 0; games 0; all pulses 0; point_to_right 0; holding 0; FSM in PLAY.
- Reset is asynchronous assert and takes effect mid-hold or mid-game; all other logic updates on clk rising edge only.
- Edge sampling:
  - prev_nL is a register loaded with nL on every move_tick.
  - A point ends on a move_tick where nL == 8'hFF and prev_nL != 8'hFF.
  - prev_nL == 8'h7F: ball exited left, so the right player wins the point.
  - prev_nL == 8'hFE: ball exited right, so the left player wins the point.
  - Any other prev_nL (reload, serve setup) awards nothing.
- point_pulse and point_to_right assert/update in the cycle after the qualifying move_tick (latency 1).
- Game FSM states: PLAY, DEUCE, ADV_L, ADV_R, HOLD.
- PLAY keeps point counters pl, pr in 0..3.
  - Winner's counter at 3 and opponent's <3: game won.
  - Winner at 2 and opponent at 3: go to DEUCE.
  - Otherwise the winner's counter increments.
- DEUCE: a point goes to ADV_L or ADV_R for the point winner; both codes display 3.
- ADV_x:
  - The same player scores: game won.
  - The other player scores: back to DEUCE.
  - Display: advantaged player 4, other player 5.
- Game won:
  - game_pulse for one cycle, concurrent with point_pulse.
  - Winner's games counter increments and saturates at GAME_LIMIT.
  - Enter HOLD showing the winner's code 3 and the loser's last code.
  - hold counter loaded with HOLD_TICKS.
- HOLD:
  - holding=1; the counter decrements each move_tick; point ends detected in HOLD are ignored.
  - On reaching 0: pl=pr=0, go to PLAY, holding=0 the next cycle.
- When both players' games equal GAME_LIMIT, the next game won clears both games counters to 0 before incrementing the winner's to 1.
- move_tick during reset is ignored; nL glitches between ticks are never sampled.

Optional Feature:
- Macro NO_AD_SCORING_EN.
- Defined:
  - DEUCE awards the game directly to the next point winner.
  - ADV_L and ADV_R are unreachable; code 4 is never output.
- Undefined: standard advantage scoring as above.

Test Plan:
- Reset mid-HOLD (holding=1, games_left=2): assert reset -> all outputs 0 and FSM PLAY immediately, without waiting for clk.
- Ball exits right four times from 0-0 (prev_nL=FE then FF each time) -> pts_left 1,2,3, then game_pulse; games_left=1; holding=1; point pulses 4, each 1 cycle after its tick.
- Reach 40-40, right scores, right scores again:
  - Without macro -> DEUCE (3/3), ADV_R (5/4), then game; games_right=1.
  - With NO_AD_SCORING_EN -> game on the first point after deuce.
- Reach ADV_L, then right scores -> DEUCE, pts 3/3, no game_pulse.
- HOLD_TICKS=6; inject a point end during HOLD -> no point_pulse; after 6 move_ticks holding=0 and pts 0/0.
- games_left=games_right=9, left wins a game -> games_left=1, games_right=0.
- nL transitions FD->FF on a tick -> no point awarded, score unchanged.

Source files
------------

// File: rtl/tennis_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tennis_score_keeper
//  Brief    : Watches the ball shift-register bus on each move tick. It
//             detects when a point ends and who won it, and runs game
//             scoring (0/15/30/40/deuce/advantage) plus per-player game
//             counts. It drives BCD-style score codes and one-cycle event
//             pulses to the display multiplexer.
//  Options  : NO_AD_SCORING_EN - when defined, the next point after deuce
//             wins the game (no advantage states, code 4 never shown).
//  Revision : 1.0 - initial release
// ============================================================================
module tennis_score_keeper #(
   parameter int GAME_LIMIT = 9,   // games count saturates here (max 15)
   parameter int HOLD_TICKS = 6    // move ticks the final score stays frozen (1..63)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       move_tick,
   input  logic [7:0] nL,
   output logic [3:0] pts_left,
   output logic [3:0] pts_right,
   output logic [3:0] games_left,
   output logic [3:0] games_right,
   output logic       point_pulse,
   output logic       point_to_right,
   output logic       game_pulse,
   output logic       holding
);

   localparam logic [7:0] c_NO_BALL    = 8'hFF;
   localparam logic [7:0] c_EXIT_LEFT  = 8'h7F;
   localparam logic [7:0] c_EXIT_RIGHT = 8'hFE;

   localparam logic [2:0] c_CODE_40    = 3'd3;
   localparam logic [2:0] c_CODE_AD    = 3'd4;
   localparam logic [2:0] c_CODE_BLANK = 3'd5;

   localparam logic [3:0] c_GAME_LIMIT = 4'(GAME_LIMIT);
   localparam logic [5:0] c_HOLD_TICKS = 6'(HOLD_TICKS);

   localparam logic [2:0] c_PLAY  = 3'd0;
   localparam logic [2:0] c_DEUCE = 3'd1;
   localparam logic [2:0] c_ADV_L = 3'd2;
   localparam logic [2:0] c_ADV_R = 3'd3;
   localparam logic [2:0] c_HOLD  = 3'd4;

   logic [7:0] r_prevNL;
   logic [2:0] r_state;
   logic [2:0] w_nextState;
   logic [2:0] r_pl;
   logic [2:0] r_pr;
   logic [2:0] w_nextPl;
   logic [2:0] w_nextPr;
   logic [3:0] r_gamesL;
   logic [3:0] r_gamesR;
   logic [5:0] r_holdCnt;
   logic       r_pointPulse;
   logic       r_pointToRight;
   logic       r_gamePulse;

   logic       w_pointEnd;
   logic       w_leftPt;
   logic       w_rightPt;
   logic       w_award;
   logic       w_gameWon;
   logic       w_holdDone;

   // A point ends when the ball leaves the bus on a tick. The last position
   // seen tells which side it left from. Any other last position (serve
   // setup, reload) awards nothing.
   assign w_pointEnd = move_tick && (nL == c_NO_BALL) && (r_prevNL != c_NO_BALL);
   assign w_leftPt   = w_pointEnd && (r_prevNL == c_EXIT_RIGHT);
   assign w_rightPt  = w_pointEnd && (r_prevNL == c_EXIT_LEFT);
   assign w_award    = (w_leftPt || w_rightPt) && (r_state != c_HOLD);
   assign w_holdDone = (r_state == c_HOLD) && move_tick && (r_holdCnt <= 6'd1);

   assign point_pulse    = r_pointPulse;
   assign point_to_right = r_pointToRight;
   assign game_pulse     = r_gamePulse;
   assign games_left     = r_gamesL;
   assign games_right    = r_gamesR;

   // Game FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_PLAY;
      else       r_state <= w_nextState;
   end

   // Next state, next point codes and game-won decision for the awarded point
   always_comb begin
      w_nextState = r_state;
      w_nextPl    = r_pl;
      w_nextPr    = r_pr;
      w_gameWon   = 1'b0;
      case (r_state)
         c_PLAY: begin
            if (w_award) begin
               if (w_rightPt) begin
                  if (r_pr == c_CODE_40 && r_pl < c_CODE_40) begin
                     w_gameWon = 1'b1;
                  end else if (r_pr == 3'd2 && r_pl == c_CODE_40) begin
                     w_nextState = c_DEUCE;
                     w_nextPr    = c_CODE_40;
                  end else begin
                     w_nextPr = r_pr + 3'd1;
                  end
               end else begin
                  if (r_pl == c_CODE_40 && r_pr < c_CODE_40) begin
                     w_gameWon = 1'b1;
                  end else if (r_pl == 3'd2 && r_pr == c_CODE_40) begin
                     w_nextState = c_DEUCE;
                     w_nextPl    = c_CODE_40;
                  end else begin
                     w_nextPl = r_pl + 3'd1;
                  end
               end
            end
         end
         c_DEUCE: begin
            if (w_award) begin
`ifdef NO_AD_SCORING_EN
               // Sudden death: both codes already read 40, winner keeps 40.
               w_gameWon = 1'b1;
`else
               w_nextState = w_rightPt ? c_ADV_R : c_ADV_L;
`endif
            end
         end
         c_ADV_L: begin
            if (w_award) begin
               if (w_leftPt) begin
                  w_gameWon = 1'b1;
                  w_nextPl  = c_CODE_40;
                  w_nextPr  = c_CODE_BLANK;
               end else begin
                  w_nextState = c_DEUCE;
               end
            end
         end
         c_ADV_R: begin
            if (w_award) begin
               if (w_rightPt) begin
                  w_gameWon = 1'b1;
                  w_nextPr  = c_CODE_40;
                  w_nextPl  = c_CODE_BLANK;
               end else begin
                  w_nextState = c_DEUCE;
               end
            end
         end
         c_HOLD: begin
            if (w_holdDone) begin
               w_nextState = c_PLAY;
               w_nextPl    = 3'd0;
               w_nextPr    = 3'd0;
            end
         end
         default: w_nextState = c_PLAY;
      endcase
      if (w_gameWon) w_nextState = c_HOLD;
   end

   // Displayed point codes and hold flag, decoded from the game state
   always_comb begin
      pts_left  = {1'b0, r_pl};
      pts_right = {1'b0, r_pr};
      holding   = 1'b0;
      case (r_state)
         c_DEUCE: begin
            pts_left  = {1'b0, c_CODE_40};
            pts_right = {1'b0, c_CODE_40};
         end
         c_ADV_L: begin
            pts_left  = {1'b0, c_CODE_AD};
            pts_right = {1'b0, c_CODE_BLANK};
         end
         c_ADV_R: begin
            pts_left  = {1'b0, c_CODE_BLANK};
            pts_right = {1'b0, c_CODE_AD};
         end
         c_HOLD:  holding = 1'b1;
         default: ;
      endcase
   end

   // Ball edge history and one-cycle point/game event pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prevNL       <= c_NO_BALL;
         r_pointPulse   <= 1'b0;
         r_gamePulse    <= 1'b0;
         r_pointToRight <= 1'b0;
      end else begin
         if (move_tick) r_prevNL <= nL;
         r_pointPulse <= w_award;
         r_gamePulse  <= w_gameWon;
         if (w_award) r_pointToRight <= w_rightPt;
      end
   end

   // Point counters and the freeze countdown that follows a won game
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pl      <= 3'd0;
         r_pr      <= 3'd0;
         r_holdCnt <= 6'd0;
      end else begin
         r_pl <= w_nextPl;
         r_pr <= w_nextPr;
         if (w_gameWon) begin
            r_holdCnt <= c_HOLD_TICKS;
         end else if (r_state == c_HOLD && move_tick && r_holdCnt != 6'd0) begin
            r_holdCnt <= r_holdCnt - 6'd1;
         end
      end
   end

   // Games counters: saturate at the limit, restart the match once both sides reach it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gamesL <= 4'd0;
         r_gamesR <= 4'd0;
      end else if (w_gameWon) begin
         if (r_gamesL == c_GAME_LIMIT && r_gamesR == c_GAME_LIMIT) begin
            r_gamesL <= w_rightPt ? 4'd0 : 4'd1;
            r_gamesR <= w_rightPt ? 4'd1 : 4'd0;
         end else if (w_rightPt) begin
            if (r_gamesR < c_GAME_LIMIT) r_gamesR <= r_gamesR + 4'd1;
         end else begin
            if (r_gamesL < c_GAME_LIMIT) r_gamesL <= r_gamesL + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tennis_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tennis_score_keeper
//  Brief    : Directed bench for tennis_score_keeper. Stimulus pushes the
//             hand-computed response of every awarded point into a queue;
//             a monitor pops and compares whenever point_pulse is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tennis_score_keeper;

   logic       clk;
   logic       reset;
   logic       move_tick;
   logic [7:0] nL;
   logic [3:0] pts_left;
   logic [3:0] pts_right;
   logic [3:0] games_left;
   logic [3:0] games_right;
   logic       point_pulse;
   logic       point_to_right;
   logic       game_pulse;
   logic       holding;

   typedef struct {
      logic [18:0] vec;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   nChecks = 0;
   int   nPass   = 0;

   tennis_score_keeper #(.GAME_LIMIT(9), .HOLD_TICKS(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .move_tick     (move_tick),
      .nL            (nL),
      .pts_left      (pts_left),
      .pts_right     (pts_right),
      .games_left    (games_left),
      .games_right   (games_right),
      .point_pulse   (point_pulse),
      .point_to_right(point_to_right),
      .game_pulse    (game_pulse),
      .holding       (holding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle index used to verify pulse latency
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [18:0] outs();
      return {point_to_right, game_pulse, pts_left, pts_right, games_left, games_right, holding};
   endfunction

   function automatic logic [16:0] snap();
      return {pts_left, pts_right, games_left, games_right, holding};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act === req) nPass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // monitor: every point pulse must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (point_pulse) begin
            if (q.size() == 0) begin
               nChecks++;
               $display("FAIL unexpected_point: got outputs %h expected no pulse", outs());
            end else begin
               e = q.pop_front();
               chk("point_cycle", cyc, e.cyc);
               chk("point_outputs", {13'd0, outs()}, {13'd0, e.vec});
            end
         end else if (game_pulse) begin
            nChecks++;
            $display("FAIL game_pulse_alone: got game_pulse 1 expected 0 without point_pulse");
         end
      end
   end

   task automatic tick(input logic [7:0] v);
      @(posedge clk); #1;
      move_tick = 1'b1;
      nL        = v;
      @(posedge clk); #1;
      move_tick = 1'b0;
   endtask

   // ball leaves the bus; right=1 means it exits left so the right player scores
   task automatic point(input bit right, input bit game, input int pl, input int pr,
                        input int gl, input int gr, input bit hold);
      exp_t e;
      tick(right ? 8'h7F : 8'hFE);
      @(posedge clk); #1;
      move_tick = 1'b1;
      nL        = 8'hFF;
      e.vec = {right, game, 4'(pl), 4'(pr), 4'(gl), 4'(gr), hold};
      e.cyc = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
      move_tick = 1'b0;
   endtask

   task automatic playGame(input bit right, input int glB, input int grB,
                           input int glA, input int grA);
      for (int i = 1; i <= 3; i++)
         point(right, 1'b0, right ? 0 : i, right ? i : 0, glB, grB, 1'b0);
      point(right, 1'b1, right ? 0 : 3, right ? 3 : 0, glA, grA, 1'b1);
   endtask

   task automatic holdOut(input int done, input int gl, input int gr);
      for (int i = done; i < 5; i++) tick(8'hFF);
      chk("hold_before_last_tick", {31'd0, holding}, 32'd1);
      tick(8'hFF);
      chk("hold_release", {15'd0, snap()}, {15'd0, 8'h00, 4'(gl), 4'(gr), 1'b0});
   endtask

   initial begin
      reset     = 1'b1;
      move_tick = 1'b0;
      nL        = 8'hFF;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_state", {13'd0, outs()}, 32'd0);

      // left wins a love game
      playGame(1'b0, 0, 0, 1, 0);
      // a point end during hold is ignored and counts as hold ticks
      tick(8'h7F);
      tick(8'hFF);
      holdOut(2, 1, 0);

      // 40-40, then right scores twice
      point(1'b0, 1'b0, 1, 0, 1, 0, 1'b0);
      point(1'b0, 1'b0, 2, 0, 1, 0, 1'b0);
      point(1'b0, 1'b0, 3, 0, 1, 0, 1'b0);
      point(1'b1, 1'b0, 3, 1, 1, 0, 1'b0);
      point(1'b1, 1'b0, 3, 2, 1, 0, 1'b0);
      point(1'b1, 1'b0, 3, 3, 1, 0, 1'b0);
`ifdef NO_AD_SCORING_EN
      point(1'b1, 1'b1, 3, 3, 1, 1, 1'b1);
`else
      point(1'b1, 1'b0, 5, 4, 1, 0, 1'b0);
      point(1'b1, 1'b1, 5, 3, 1, 1, 1'b1);
`endif
      holdOut(0, 1, 1);

`ifdef NO_AD_SCORING_EN
      playGame(1'b0, 1, 1, 2, 1);
`else
      // advantage left lost back to deuce, then left takes the game
      point(1'b0, 1'b0, 1, 0, 1, 1, 1'b0);
      point(1'b0, 1'b0, 2, 0, 1, 1, 1'b0);
      point(1'b0, 1'b0, 3, 0, 1, 1, 1'b0);
      point(1'b1, 1'b0, 3, 1, 1, 1, 1'b0);
      point(1'b1, 1'b0, 3, 2, 1, 1, 1'b0);
      point(1'b1, 1'b0, 3, 3, 1, 1, 1'b0);
      point(1'b0, 1'b0, 4, 5, 1, 1, 1'b0);
      point(1'b1, 1'b0, 3, 3, 1, 1, 1'b0);
      point(1'b0, 1'b0, 4, 5, 1, 1, 1'b0);
      point(1'b0, 1'b1, 3, 5, 2, 1, 1'b1);
`endif

      // asynchronous reset in the middle of a hold
      tick(8'hFF);
      tick(8'hFF);
`ifdef NO_AD_SCORING_EN
      chk("pre_reset", {15'd0, snap()}, {15'd0, 4'd3, 4'd0, 4'd2, 4'd1, 1'b1});
`else
      chk("pre_reset", {15'd0, snap()}, {15'd0, 4'd3, 4'd5, 4'd2, 4'd1, 1'b1});
`endif
      @(negedge clk); #2;
      reset = 1'b1;
      #1 chk("async_reset", {13'd0, outs()}, 32'd0);
      // a tick during reset must not load the ball history
      @(posedge clk); #1;
      move_tick = 1'b1;
      nL        = 8'hFE;
      @(posedge clk); #1;
      move_tick = 1'b0;
      nL        = 8'hFF;
      @(posedge clk); #1;
      reset = 1'b0;
      tick(8'hFF);
      chk("tick_in_reset_ignored", {15'd0, snap()}, 32'd0);

      // non-exit positions and between-tick glitches award nothing
      tick(8'hFD);
      tick(8'hFF);
      chk("fd_to_ff_no_point", {15'd0, snap()}, 32'd0);
      @(posedge clk); #1 nL = 8'h7F;
      @(posedge clk); #1 nL = 8'hFF;
      tick(8'hFF);
      chk("glitch_not_sampled", {15'd0, snap()}, 32'd0);

      // alternate games up to 9-9, then the match counters restart
      for (int k = 1; k <= 9; k++) begin
         playGame(1'b0, k - 1, k - 1, k, k - 1);
         holdOut(0, k, k - 1);
         playGame(1'b1, k, k - 1, k, k);
         holdOut(0, k, k);
      end
      playGame(1'b0, 9, 9, 1, 0);
      holdOut(0, 1, 0);

      // left alone climbs to the limit and saturates there
      for (int k = 2; k <= 9; k++) begin
         playGame(1'b0, k - 1, 0, k, 0);
         holdOut(0, k, 0);
      end
      playGame(1'b0, 9, 0, 9, 0);
      holdOut(0, 9, 0);

      repeat (5) @(posedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
